// File: rtl/regf_pkg.sv
// Shared register-file constants, imported by the register file and the writeback scheduler.
package regf_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned NREGS = 32;

  localparam logic [RA_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; after reset req0 has priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // 0: req0 wins a tie, 1: req1 wins a tie
  logic ptr_q;

  // Grant the lone requester, or break a tie using the pointer
  always_comb begin
    grant = req;
    if (&req) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After any grant, favour the requester that was not granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (|grant) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/regf_wb_sched.sv
// Writeback scheduler: scoreboard of pending writes, ALU/load writeback arbitration and a
// registered register-file write port.
module regf_wb_sched
  import regf_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [RA_W-1:0]  issue_rd,
  output logic             issue_ready,
  input  logic [RA_W-1:0]  rs0,
  input  logic [RA_W-1:0]  rs1,
  output logic             rs_hazard,
  input  logic             req0_valid,
  input  logic [RA_W-1:0]  req0_rd,
  input  logic [XLEN-1:0]  req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [RA_W-1:0]  req1_rd,
  input  logic [XLEN-1:0]  req1_data,
  output logic             req1_ready,
  output logic             we,
  output logic [RA_W-1:0]  waddr,
  output logic [XLEN-1:0]  wdata,
  output logic [NREGS-1:0] busy,
  output logic             err
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             we_q;
  logic [RA_W-1:0]  waddr_q;
  logic [XLEN-1:0]  wdata_q;
  logic             err_q;

  logic [1:0]       req, grant;
  logic             gnt_valid, gnt_write;
  logic [RA_W-1:0]  gnt_rd;
  logic [XLEN-1:0]  gnt_data;
  logic             issue_fire;

  assign req = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign gnt_valid  = |grant;
  assign gnt_rd     = grant[1] ? req1_rd : req0_rd;
  assign gnt_data   = grant[1] ? req1_data : req0_data;
  // Writes to x0 still complete the handshake but never reach the register file
  assign gnt_write  = gnt_valid && (gnt_rd != REG_X0);

  assign issue_ready = (issue_rd == REG_X0) || !busy_q[issue_rd];
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != REG_X0);
  assign rs_hazard   = ((rs0 != REG_X0) && busy_q[rs0]) || ((rs1 != REG_X0) && busy_q[rs1]);

  // Scoreboard next state: clear on committed write, then set on issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard, write-port register and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      we_q   <= gnt_write;
      if (gnt_write) begin
        waddr_q <= gnt_rd;
        wdata_q <= gnt_data;
      end
      // A writeback to a register nobody is waiting on indicates a pipeline bug upstream
      if (gnt_write && !busy_q[gnt_rd]) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy  = busy_q;
  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign err   = err_q;

endmodule
